// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryptor: the cipher key is expanded forward into a round-key
// store, then one inverse round runs per clock. A single-entry key cache skips expansion.
package aes128_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            acc = gmul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        case (j)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// Forward S-box, used only by the key schedule.
module aes128_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    import aes128_inv_pkg::*;
    logic [7:0] b;
    assign b   = gf_inv(a_i);
    assign s_o = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
endmodule

// Inverse S-box: undo the affine map, then invert in GF(2^8).
module inv_sbox (
    input  logic [7:0] s_i,
    output logic [7:0] a_o
);
    import aes128_inv_pkg::*;
    logic [7:0] b;
    assign b   = rotl(s_i, 1) ^ rotl(s_i, 3) ^ rotl(s_i, 6) ^ 8'h05;
    assign a_o = gf_inv(b);
endmodule

module aes128_inv_cipher_iter #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] data,
    input  logic [0:127] key128,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out128,
    output logic         out_valid,
    input  logic         out_ready
);
    import aes128_inv_pkg::*;

    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

    localparam logic [3:0] RND_LAST = 4'(ROUNDS);

    state_t       state_q;
    logic [3:0]   rnd_q;
    logic [0:127] x_q;
    logic [0:127] out_q;
    logic         cache_vld_q;
    logic         in_ready_q;
    logic         out_valid_q;
    // Sized for the maximum round count so the 4-bit round counter indexes it exactly
    logic [0:127] rk_q [0:10];

    logic [3:0]   rk_idx;
    logic [0:127] rk_prev;
    logic         hit;

    // KEXP reads rk[j-1] and DEC reads rk[r-1], so one read port serves both
    assign rk_idx  = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign rk_prev = rk_q[rk_idx];
    assign hit     = cache_vld_q && (key128 == rk_q[0]);

    logic [0:31]  w3;
    logic [0:31]  sw;
    logic [0:31]  temp;
    logic [0:31]  w4, w5, w6, w7;
    logic [0:127] nk;

    assign w3 = rk_prev[96:127];
    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes128_sbox u_sb (
            .a_i (w3[8*((i+1)%4) +: 8]),
            .s_o (sw[8*i +: 8])
        );
    end
    assign temp = sw ^ {rcon(rnd_q), 24'h000000};
    assign w4   = rk_prev[0:31]   ^ temp;
    assign w5   = rk_prev[32:63]  ^ w4;
    assign w6   = rk_prev[64:95]  ^ w5;
    assign w7   = rk_prev[96:127] ^ w6;
    assign nk   = {w4, w5, w6, w7};

    logic [0:127] isr;
    logic [0:127] isb;
    logic [0:127] ark;
    logic [0:127] imc;

    assign isr = inv_shift_rows(x_q);
    for (genvar i = 0; i < 16; i++) begin : g_isb
        inv_sbox u_isb (
            .s_i (isr[8*i +: 8]),
            .a_o (isb[8*i +: 8])
        );
    end
    assign ark = isb ^ rk_prev;
    assign imc = inv_mix_columns(ark);

    // Round-key store carries no reset; cache_vld_q guards every read that matters
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid && !hit)
            rk_q[0] <= key128;
        else if (state_q == KEXP)
            rk_q[rnd_q] <= nk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            x_q         <= '0;
            out_q       <= '0;
            cache_vld_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (hit) begin
                            x_q     <= data ^ rk_q[ROUNDS];
                            rnd_q   <= RND_LAST;
                            state_q <= DEC;
                        end else begin
                            x_q         <= data;
                            cache_vld_q <= 1'b0;
                            rnd_q       <= 4'd1;
                            state_q     <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    if (rnd_q == RND_LAST) begin
                        x_q         <= x_q ^ nk;
                        cache_vld_q <= 1'b1;
                        state_q     <= DEC;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DEC: begin
                    if (rnd_q == 4'd1) begin
                        out_q       <= ark;
                        out_valid_q <= 1'b1;
                        rnd_q       <= 4'd0;
                        state_q     <= DONE;
                    end else begin
                        x_q   <= imc;
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out128    = out_q;

endmodule
